pill_feeder: RTL
================

Name: pill_feeder

Overview:
- Behavioural hopper/dispenser for the pill-bottling line.
- The bottling controller opens the valve and counts pill-sensor pulses; this block is the other end of that interface.
- While the valve is open it drops pills at a fixed rate and emits one SensorP pulse per pill. It also tracks hopper level, refills and a lifetime dispensed count.
- Used as the plant model in system benches and as the drive for the dispenser actuator.

Parameters:
- PERIOD, 4, clock cycles spent in GAP before each pill drop (≥1).
- PULSE_W, 1, SensorP high time per pill in cycles (≥1).
- HOPPER_MAX, 255, saturation limit of hopper level (≤255).
- INIT_LEVEL, 0, hopper level after reset.

Ports:
- Clk  in  1  single system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Valve  in  1  valve command from the controller: 1 = closed, 0 = open (dispense).
- Refill  in  1  one-cycle strobe: add RefillQty to the hopper.
- RefillQty  in  8  pills added on Refill.
- ClrCount  in  1  synchronous clear of Dispensed.
- SensorP  out  1  pill-passed pulse, PULSE_W cycles per pill.
- Empty  out  1  Level == 0.
- Level  out  8  current hopper content.
- Dispensed  out  16  total pills dropped since reset/clear; wraps modulo 2^16.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE, SensorP=0, Level=INIT_LEVEL, Dispensed=0, gap/pulse counters=0.
  - Outputs take these values immediately, independent of Clk.
  - Reset mid-DROP truncates the pulse; no further pulse after release.
- States:
  - IDLE: Valve=0 and Level>0 -> GAP with cnt=PERIOD-1. Valve=0 and Level=0 -> EMPTY. Otherwise stay.
  - GAP: Valve=1 -> IDLE, pill aborted, no pulse, Level unchanged. cnt==0 -> DROP, with Level decremented and Dispensed incremented on this transition. Otherwise cnt-1.
  - DROP: SensorP=1 for PULSE_W cycles. Valve changes do not cut the pulse; a dropped pill is always reported. At pulse end: Valve=0 and Level>0 -> GAP (cnt=PERIOD-1); Valve=0 and Level=0 -> EMPTY; Valve=1 -> IDLE.
  - EMPTY: Valve=1 -> IDLE. Level>0 (after refill) -> GAP with cnt=PERIOD-1.
- Timing:
  - SensorP is registered and high only in DROP.
  - Steady-state pill spacing is PERIOD+PULSE_W cycles.
  - The first pulse rises PERIOD+1 edges after the edge that samples Valve=0 in IDLE.
- Level arithmetic, 9-bit internal, saturating:
  - next = min(Level − dec + (Refill ? RefillQty : 0), HOPPER_MAX), where dec=1 on the GAP->DROP transition.
  - Simultaneous refill and decrement are both applied in the same cycle.
  - Refill is accepted in every state.
  - A decrement never occurs at Level=0, since GAP is only entered with Level>0.
- Dispensed:
  - +1 per drop, wraps from 0xFFFF to 0.
  - ClrCount has priority over a same-cycle increment: result is 0.
- Empty is combinational from Level.

Decomposition:
- Package pill_line_pkg:
  - feeder state typedef (IDLE, GAP, DROP, EMPTY; 2-bit encoding).
  - constants for valve polarity (VALVE_OPEN=0, VALVE_CLOSED=1), shared with the bottling controller.
- Sub-module pill_gap_timer: loadable down-counter with load value, enable and zero flag.
  - Instantiated twice: GAP interval and DROP pulse width.

Test Plan:
1. Reset, Refill with RefillQty=10, Valve held 0, PERIOD=4, PULSE_W=1 -> exactly 10 one-cycle SensorP pulses spaced 5 cycles apart, first on the 5th edge after Valve sampled 0; then Level=0, Empty=1, Dispensed=10, state EMPTY.
2. Level=5, Valve=0, then Valve=1 after 2 GAP cycles -> no pulse; Level stays 5; Dispensed unchanged; IDLE. With PULSE_W=3 and Valve=1 asserted in the first DROP cycle -> SensorP stays high the full 3 cycles.
3. Level=250 with Refill, RefillQty=20 -> Level=255. Level=1 with Refill, RefillQty=7 on the GAP->DROP edge -> Level=7 and the pulse occurs.
4. EMPTY with Valve=0, Refill with RefillQty=3 -> dispensing resumes after PERIOD cycles; 3 pulses; back to EMPTY.
5. Rst_n low mid-DROP, asynchronous to Clk -> SensorP=0 and Level=INIT_LEVEL before the next edge; Dispensed=0.
6. Dispensed preset near wrap at 0xFFFF plus one drop -> 0x0000. ClrCount in the same cycle as a drop -> 0.

Source files
------------

// File: rtl/pill_line_pkg.sv
// Shared types and constants for the pill-bottling line (feeder and controller).
package pill_line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DROP  = 2'd2,
    EMPTY = 2'd3
  } feeder_state_e;

  localparam logic VALVE_OPEN   = 1'b0;
  localparam logic VALVE_CLOSED = 1'b1;

  // Clamp a 9-bit intermediate hopper level to the configured ceiling.
  function automatic logic [7:0] sat_level(input logic [8:0] v, input logic [8:0] lim);
    return (v > lim) ? lim[7:0] : v[7:0];
  endfunction

endpackage

// File: rtl/pill_feeder_if.sv
// Controller <-> feeder signal bundle; master is the bottling controller side.
interface pill_feeder_if;
  logic        Valve;
  logic        Refill;
  logic [7:0]  RefillQty;
  logic        ClrCount;
  logic        SensorP;
  logic        Empty;
  logic [7:0]  Level;
  logic [15:0] Dispensed;

  modport master (output Valve, Refill, RefillQty, ClrCount,
                  input  SensorP, Empty, Level, Dispensed);
  modport slave  (input  Valve, Refill, RefillQty, ClrCount,
                  output SensorP, Empty, Level, Dispensed);
endinterface

// File: rtl/pill_gap_timer.sv
// Loadable down-counter that parks at zero; zero flag reports expiry.
module pill_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/pill_feeder.sv
// Hopper/dispenser plant: drops one pill every PERIOD+PULSE_W cycles while the
// valve is open, pulsing SensorP per pill and tracking level and lifetime count.
module pill_feeder
  import pill_line_pkg::*;
#(
  parameter int PERIOD     = 4,
  parameter int PULSE_W    = 1,
  parameter int HOPPER_MAX = 255,
  parameter int INIT_LEVEL = 0
) (
  input  logic          Clk,
  input  logic          Rst_n,
  pill_feeder_if.slave  bus
);
  localparam int             TW        = 16;
  localparam logic [TW-1:0]  GAP_LOAD  = TW'(PERIOD - 1);
  localparam logic [TW-1:0]  PW_LOAD   = TW'(PULSE_W - 1);
  localparam logic [8:0]     LEVEL_LIM = 9'(HOPPER_MAX);

  feeder_state_e state_q, state_d;
  logic          valve_q, valve_d;
  logic          sensor_q, sensor_d;
  logic [7:0]    level_q, level_d;
  logic [15:0]   disp_q, disp_d;
  logic [8:0]    level_sum;
  logic          gap_load, gap_en, gap_zero;
  logic          pw_load, pw_en, pw_zero;
  logic          dec;

  pill_gap_timer #(.W(TW)) u_gap (
    .clk(Clk), .rst_n(Rst_n), .load(gap_load), .load_val(GAP_LOAD),
    .en(gap_en), .zero(gap_zero)
  );

  pill_gap_timer #(.W(TW)) u_pulse (
    .clk(Clk), .rst_n(Rst_n), .load(pw_load), .load_val(PW_LOAD),
    .en(pw_en), .zero(pw_zero)
  );

  // Valve is registered once, so the first pill lands PERIOD+1 edges after it is seen.
  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    pw_load  = 1'b0;
    pw_en    = 1'b0;
    dec      = 1'b0;
    unique case (state_q)
      IDLE:
        if (valve_q == VALVE_OPEN) begin
          if (|level_q) begin state_d = GAP; gap_load = 1'b1; end
          else          state_d = EMPTY;
        end
      GAP:
        if (valve_q == VALVE_CLOSED) state_d = IDLE;
        else if (gap_zero) begin
          state_d = DROP;
          dec     = 1'b1;
          pw_load = 1'b1;
        end
        else gap_en = 1'b1;
      // Once a pill has dropped its pulse always completes, whatever the valve does.
      DROP:
        if (!pw_zero)                     pw_en   = 1'b1;
        else if (valve_q == VALVE_CLOSED) state_d = IDLE;
        else if (|level_q) begin state_d = GAP; gap_load = 1'b1; end
        else                              state_d = EMPTY;
      EMPTY:
        if (valve_q == VALVE_CLOSED) state_d = IDLE;
        else if (|level_q) begin state_d = GAP; gap_load = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valve_d   = bus.Valve;
    sensor_d  = (state_d == DROP);
    level_sum = {1'b0, level_q} + (bus.Refill ? {1'b0, bus.RefillQty} : 9'd0) - {8'd0, dec};
    level_d   = sat_level(level_sum, LEVEL_LIM);
    disp_d    = bus.ClrCount ? 16'd0 : disp_q + {15'd0, dec};
  end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q  <= IDLE;
      valve_q  <= VALVE_CLOSED;
      sensor_q <= 1'b0;
      level_q  <= 8'(INIT_LEVEL);
      disp_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      valve_q  <= valve_d;
      sensor_q <= sensor_d;
      level_q  <= level_d;
      disp_q   <= disp_d;
    end

  assign bus.SensorP   = sensor_q;
  assign bus.Level     = level_q;
  assign bus.Empty     = (level_q == 8'd0);
  assign bus.Dispensed = disp_q;
endmodule
